// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: lane steering, load extraction, a two-state wait FSM
// that stalls the pipeline until memory completes, and the M->W pipeline register.
module load_store_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [4:0]       RdM,
  input  logic [WIDTH-1:0] PCPlus4M,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  output logic             StallM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [4:0]       RdW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic             MisalignW
);

  localparam int unsigned BE_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e state_q;

  // Access latched when memory does not answer in the issuing cycle
  logic [WIDTH-1:0] addr_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]  be_q;
  logic [4:0]       rd_q;
  logic             regwrite_q;
  logic [1:0]       resultsrc_q;
  logic [WIDTH-1:0] pcplus4_q;

  logic             regwrite_w_q, regwrite_w_d;
  logic [1:0]       resultsrc_w_q, resultsrc_w_d;
  logic [WIDTH-1:0] aluresult_w_q, aluresult_w_d;
  logic [WIDTH-1:0] readdata_w_q, readdata_w_d;
  logic [4:0]       rd_w_q, rd_w_d;
  logic [WIDTH-1:0] pcplus4_w_q, pcplus4_w_d;
  logic             misalign_w_q, misalign_w_d;

  logic             access_m;
  logic             legal_m;
  logic             misalign_m;
  logic             ok_m;
  logic             fault_m;
  logic [WIDTH-1:0] wdata_m;
  logic [BE_W-1:0]  be_m;

  // Select the addressed lane and sign/zero extend it to the register width
  function automatic logic [WIDTH-1:0] load_value(input logic [2:0]       f3,
                                                  input logic [1:0]       off,
                                                  input logic [WIDTH-1:0] rdata);
    logic [WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  return {{(WIDTH-16){sh[15]}}, sh[15:0]};
      3'b100:  return WIDTH'(sh[7:0]);
      3'b101:  return WIDTH'(sh[15:0]);
      default: return sh;
    endcase
  endfunction

  // Decode of the live M-stage access
  always_comb begin
    access_m   = MemReadM | MemWriteM;
    legal_m    = MemWriteM ? (Funct3M inside {3'b000, 3'b001, 3'b010})
                           : (Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign_m = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
    ok_m       = access_m & legal_m & ~misalign_m;
    fault_m    = access_m & ~ok_m;

    wdata_m = WriteDataM;
    be_m    = 4'b1111;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          wdata_m = {(WIDTH/8){WriteDataM[7:0]}};
          be_m    = 4'b0001 << ALUResultM[1:0];
        end
        2'b01: begin
          wdata_m = {(WIDTH/16){WriteDataM[15:0]}};
          be_m    = 4'b0011 << {ALUResultM[1], 1'b0};
        end
        default: begin
          wdata_m = WriteDataM;
          be_m    = 4'b1111;
        end
      endcase
    end
  end

  // Memory request: live inputs when idle, latched access while waiting
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    StallM    = 1'b0;
    if (!rst) begin
      if (state_q == S_WAIT) begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
        mem_wdata = wdata_q;
        mem_be    = be_q;
        StallM    = ~mem_ready;
      end else if (ok_m) begin
        mem_req   = 1'b1;
        mem_we    = MemWriteM;
        mem_addr  = {ALUResultM[WIDTH-1:2], 2'b00};
        mem_wdata = wdata_m;
        mem_be    = be_m;
        StallM    = ~mem_ready;
      end
    end
  end

  // Next writeback register contents; a stall inserts a bubble
  always_comb begin
    regwrite_w_d  = 1'b0;
    resultsrc_w_d = '0;
    aluresult_w_d = '0;
    readdata_w_d  = '0;
    rd_w_d        = '0;
    pcplus4_w_d   = '0;
    misalign_w_d  = 1'b0;
    if (!StallM) begin
      if (state_q == S_WAIT) begin
        regwrite_w_d  = regwrite_q;
        resultsrc_w_d = resultsrc_q;
        aluresult_w_d = addr_q;
        rd_w_d        = rd_q;
        pcplus4_w_d   = pcplus4_q;
        readdata_w_d  = we_q ? '0 : load_value(funct3_q, addr_q[1:0], mem_rdata);
      end else begin
        regwrite_w_d  = RegWriteM;
        resultsrc_w_d = ResultSrcM;
        aluresult_w_d = ALUResultM;
        rd_w_d        = RdM;
        pcplus4_w_d   = PCPlus4M;
        if (fault_m) begin
          regwrite_w_d = 1'b0;
          misalign_w_d = 1'b1;
        end else if (ok_m && !MemWriteM) begin
          readdata_w_d = load_value(Funct3M, ALUResultM[1:0], mem_rdata);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      funct3_q      <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      resultsrc_q   <= '0;
      pcplus4_q     <= '0;
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      rd_w_q        <= '0;
      pcplus4_w_q   <= '0;
      misalign_w_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        if (ok_m && !mem_ready) begin
          state_q     <= S_WAIT;
          addr_q      <= ALUResultM;
          funct3_q    <= Funct3M;
          we_q        <= MemWriteM;
          wdata_q     <= wdata_m;
          be_q        <= be_m;
          rd_q        <= RdM;
          regwrite_q  <= RegWriteM;
          resultsrc_q <= ResultSrcM;
          pcplus4_q   <= PCPlus4M;
        end
      end else if (mem_ready) begin
        state_q <= S_IDLE;
      end
      regwrite_w_q  <= regwrite_w_d;
      resultsrc_w_q <= resultsrc_w_d;
      aluresult_w_q <= aluresult_w_d;
      readdata_w_q  <= readdata_w_d;
      rd_w_q        <= rd_w_d;
      pcplus4_w_q   <= pcplus4_w_d;
      misalign_w_q  <= misalign_w_d;
    end
  end

  assign RegWriteW  = regwrite_w_q;
  assign ResultSrcW = resultsrc_w_q;
  assign ALUResultW = aluresult_w_q;
  assign ReadDataW  = readdata_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pcplus4_w_q;
  assign MisalignW  = misalign_w_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against an instruction-level model of the unit.
module tb_load_store_unit;

  typedef struct packed {
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        MisalignW;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: an instruction the memory has not yet answered
  bit     m_pend = 1'b0;
  instr_t m_p;
  bit     n_pend;
  instr_t n_p;

  logic        e_rw;
  logic [1:0]  e_rs;
  logic [31:0] e_alu;
  logic [31:0] e_rdat;
  logic [4:0]  e_rd;
  logic [31:0] e_pc4;
  logic        e_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_ok(input instr_t i);
    bit legal;
    if (!(i.memread || i.memwrite)) return 1'b0;
    if (i.memwrite) legal = (i.funct3 < 3'd3);
    else legal = (i.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return legal && ((i.alu % acc_size(i.funct3)) == 0);
  endfunction

  function automatic logic [3:0] model_be(input instr_t i);
    logic [3:0] be;
    int unsigned off;
    int unsigned sz;
    if (!i.memwrite) return 4'hF;
    be  = 4'h0;
    off = i.alu % 4;
    sz  = acc_size(i.funct3);
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + sz) be[k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input instr_t i);
    logic [31:0] r;
    int unsigned sz;
    sz = acc_size(i.funct3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = i.wdata[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input instr_t i, input logic [31:0] rdata);
    longint v;
    int unsigned off;
    int unsigned sz;
    v   = 0;
    off = i.alu % 4;
    sz  = acc_size(i.funct3);
    for (int j = 0; j < sz; j++) v += longint'(rdata[8*(off+j) +: 8]) << (8*j);
    if (!i.funct3[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
    return 32'(v);
  endfunction

  function automatic instr_t mk(input logic rw, input logic rd_en, input logic wr_en,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] rd);
    instr_t i;
    i.regwrite = rw;  i.resultsrc = 2'd1; i.memread = rd_en; i.memwrite = wr_en;
    i.funct3 = f3;    i.alu = alu;        i.wdata = wd;      i.rd = rd;
    i.pc4 = alu + 32'd4;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    logic [2:0] lf [5];
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    k = $urandom_range(0, 9);
    i.regwrite  = 1'($urandom);
    i.resultsrc = 2'($urandom);
    i.memread   = (k >= 3 && k <= 5) || k == 9;
    i.memwrite  = (k >= 6);
    if ($urandom_range(0, 9) == 0) i.funct3 = 3'($urandom);
    else if (i.memwrite) i.funct3 = lf[$urandom_range(0, 2)];
    else i.funct3 = lf[$urandom_range(0, 4)];
    i.alu = $urandom;
    if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
    i.wdata = $urandom;
    i.rd    = 5'($urandom);
    i.pc4   = $urandom;
    return i;
  endfunction

  // Apply one cycle of inputs, check the request side and predict the W register
  task automatic drive(input instr_t in, input logic rdy, input logic [31:0] rdat, input logic r);
    instr_t cur;
    bit     active;
    @(negedge clk);
    rst = r;
    RegWriteM = in.regwrite; ResultSrcM = in.resultsrc; MemReadM = in.memread;
    MemWriteM = in.memwrite; Funct3M = in.funct3;       ALUResultM = in.alu;
    WriteDataM = in.wdata;   RdM = in.rd;               PCPlus4M = in.pc4;
    mem_ready = rdy; mem_rdata = rdat;
    #1;
    cur    = m_pend ? m_p : in;
    active = !r && (m_pend || is_ok(in));
    chk("mem_req", 32'(mem_req), 32'(active));
    chk("StallM", 32'(StallM), 32'(active && !rdy));
    if (active) begin
      chk("mem_we", 32'(mem_we), 32'(cur.memwrite));
      chk("mem_addr", mem_addr, cur.alu & ~32'd3);
      chk("mem_be", 32'(mem_be), 32'(model_be(cur)));
      if (cur.memwrite) chk("mem_wdata", mem_wdata, model_wdata(cur));
    end
    {e_rw, e_rs, e_alu, e_rdat, e_rd, e_pc4, e_mis} = '0;
    n_pend = 1'b0;
    n_p    = m_p;
    if (!r && active && !rdy) begin
      n_pend = 1'b1;
      n_p    = cur;
    end else if (!r) begin
      e_rw = cur.regwrite; e_rs = cur.resultsrc; e_alu = cur.alu;
      e_rd = cur.rd;       e_pc4 = cur.pc4;
      if (!m_pend && (in.memread || in.memwrite) && !is_ok(in)) begin
        e_rw  = 1'b0;
        e_mis = 1'b1;
      end else if (cur.memread && !cur.memwrite) begin
        e_rdat = model_load(cur, rdat);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
    chk("ResultSrcW", 32'(ResultSrcW), 32'(e_rs));
    chk("ALUResultW", ALUResultW, e_alu);
    chk("ReadDataW", ReadDataW, e_rdat);
    chk("RdW", 32'(RdW), 32'(e_rd));
    chk("PCPlus4W", PCPlus4W, e_pc4);
    chk("MisalignW", 32'(MisalignW), 32'(e_mis));
    m_pend = n_pend;
    m_p    = n_p;
  endtask

  initial begin
    instr_t nop;
    instr_t i;
    logic   r;
    logic   rdy;
    rst = 1'b1;
    RegWriteM = 1'b0; ResultSrcM = '0; MemReadM = 1'b0; MemWriteM = 1'b0;
    Funct3M = '0; ALUResultM = '0; WriteDataM = '0; RdM = '0; PCPlus4M = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    nop = '0;

    // Reset, with a live load and ready on the inputs
    drive(nop, 1'b0, 32'h0, 1'b1); tick();
    drive(mk(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 5'd3), 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("rst_req", 32'(mem_req), 32'd0);
    tick();
    chk("rst_rw", 32'(RegWriteW), 32'd0);
    chk("rst_rdat", ReadDataW, 32'd0);

    // LB from 0x103
    drive(mk(1'b1, 1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd5), 1'b1, 32'h80FF_1234, 1'b0);
    chk("lb_stall", 32'(StallM), 32'd0);
    tick();
    chk("lb_rdat", ReadDataW, 32'hFFFF_FF80);
    chk("lb_rw", 32'(RegWriteW), 32'd1);

    // SH to 0x202
    drive(mk(1'b0, 1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 5'd0), 1'b1, 32'h0, 1'b0);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(mem_we), 32'd1);
    tick();

    // LW from 0x40 answered after three stalled cycles
    i = mk(1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 5'd7);
    for (int c = 0; c < 3; c++) begin
      drive(i, 1'b0, 32'h1111_1111, 1'b0);
      chk("lw_stall", 32'(StallM), 32'd1);
      tick();
      chk("lw_bubble_rd", 32'(RdW), 32'd0);
    end
    drive(i, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("lw_done_stall", 32'(StallM), 32'd0);
    tick();
    chk("lw_rdat", ReadDataW, 32'hDEAD_BEEF);
    chk("lw_rd", 32'(RdW), 32'd7);

    // Misaligned LW
    drive(mk(1'b1, 1'b1, 1'b0, 3'd2, 32'h41, 32'h0, 5'd8), 1'b1, 32'h0, 1'b0);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_stall", 32'(StallM), 32'd0);
    tick();
    chk("mis_flag", 32'(MisalignW), 32'd1);
    chk("mis_rw", 32'(RegWriteW), 32'd0);

    // Reset while waiting, then a late ready must be ignored
    drive(mk(1'b1, 1'b1, 1'b0, 3'd2, 32'h80, 32'h0, 5'd9), 1'b0, 32'h0, 1'b0); tick();
    drive(nop, 1'b0, 32'h0, 1'b1);
    chk("rstw_req", 32'(mem_req), 32'd0);
    tick();
    drive(nop, 1'b1, 32'h5555_5555, 1'b0);
    chk("late_req", 32'(mem_req), 32'd0);
    chk("late_stall", 32'(StallM), 32'd0);
    tick();
    chk("late_rw", 32'(RegWriteW), 32'd0);
    chk("late_rdat", ReadDataW, 32'd0);

    // LHU from 0x2 followed by an ALU instruction
    drive(mk(1'b1, 1'b1, 1'b0, 3'd5, 32'h2, 32'h0, 5'd10), 1'b1, 32'h8765_4321, 1'b0);
    chk("lhu_stall", 32'(StallM), 32'd0);
    tick();
    chk("lhu_rdat", ReadDataW, 32'h0000_8765);
    drive(mk(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd11), 1'b1, 32'h0, 1'b0);
    chk("add_stall", 32'(StallM), 32'd0);
    tick();
    chk("add_alu", ALUResultW, 32'h1234);
    chk("add_rw", 32'(RegWriteW), 32'd1);
    chk("add_rdat", ReadDataW, 32'd0);

    // Random traffic; inputs are scrambled while a stall holds the pipeline
    for (int n = 0; n < 3000; n++) begin
      i   = rand_instr();
      r   = ($urandom_range(0, 49) == 0);
      rdy = ($urandom_range(0, 99) < 45);
      drive(i, rdy, $urandom, r);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath and address width.
REQ-002 Ports, clock and reset first (clock clk; reset rst, synchronous, active-high):
- clk  in  1  CPU clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- RegWriteM  in  1  register-write enable from execute/memory pipeline register.
- ResultSrcM  in  2  writeback result select, flows through.
- MemReadM  in  1  load access in M.
- MemWriteM  in  1  store access in M.
- Funct3M  in  3  access size and signedness.
- ALUResultM  in  WIDTH  effective address / ALU result.
- WriteDataM  in  WIDTH  store data, low bits valid.
- RdM  in  5  destination register.
- PCPlus4M  in  WIDTH  flows through.
- mem_ready  in  1  data memory completion strobe.
- mem_rdata  in  WIDTH  word read data, valid with mem_ready.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  word address, bits [1:0] = 0.
- mem_wdata  out  WIDTH  lane-aligned store data.
- mem_be  out  4  byte enables.
- StallM  out  1  to hazard unit; freezes F/D/E/M while high.
- RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W  out  1/2/WIDTH/WIDTH/5/WIDTH  writeback pipeline register.
- MisalignW  out  1  registered fault flag for the instruction in W.

Function
REQ-003 Access = MemReadM|MemWriteM; both high together is treated as a store.
REQ-004 Legal Funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores); other codes are illegal.
REQ-005 Misaligned = H with addr[0]=1, or W with addr[1:0]!=0; misaligned or illegal access issues no mem_req, no stall, and loads MisalignW=1 and RegWriteW=0.
REQ-006 FSM states IDLE, WAIT; reset state IDLE.
REQ-007 IDLE with legal aligned access: mem_req=1 combinationally, from live M inputs; mem_ready=1 same cycle completes with zero stall; otherwise StallM=1 and next state WAIT with address, Funct3, we, wdata, be, Rd, RegWrite, ResultSrc, PCPlus4 latched.
REQ-008 WAIT: mem_req=1 driven from latched values only; StallM=1 until mem_ready=1; on mem_ready, StallM=0 that cycle, next state IDLE.
REQ-009 mem_req is never high for more than one access per completion; back-to-back accesses in consecutive cycles are supported from IDLE.
REQ-010 Store lanes: SB wdata = byte replicated x4, be = 0001<<addr[1:0]; SH wdata = half replicated x2, be = 0011<<(2*addr[1]); SW be=1111.
REQ-011 Loads: be=1111, mem_we=0; extract lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-012 W register update each edge: StallM=1 loads bubble (RegWriteW=0, RdW=0, MisalignW=0, others 0); otherwise loads M fields (latched fields if completing from WAIT) and ReadDataW = extracted load value (0 for non-loads).
REQ-013 Non-memory instructions pass to W with one-cycle latency, no stall.
REQ-014 mem_rdata is ignored unless mem_ready=1 and a load is outstanding.

Reset
REQ-015 rst=1 at an edge: state IDLE, all W outputs 0, latched fields 0.
REQ-016 While rst=1, mem_req=0 and StallM=0 regardless of inputs; reset during WAIT abandons the access, and a later mem_ready is ignored.

Verification
REQ-017 LB, addr 0x103, mem_rdata 0x80FF_1234, ready same cycle -> StallM=0, next cycle ReadDataW=0xFFFF_FF80, RegWriteW=1.
REQ-018 SH, addr 0x202, WriteDataM 0x0000_ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we=1.
REQ-019 LW, addr 0x40, mem_ready high after 3 cycles -> StallM high 3 cycles, W bubbles for 3 cycles, then ReadDataW = mem_rdata, RdW correct.
REQ-020 LW, addr 0x41 -> mem_req=0, StallM=0, next cycle MisalignW=1, RegWriteW=0.
REQ-021 rst asserted in WAIT, then mem_ready pulsed -> state IDLE, mem_req=0, W outputs 0, no writeback.
REQ-022 LHU, addr 0x2 then add instruction next cycle, both ready immediately -> ReadDataW = upper half zero-extended, then add result with RegWriteW=1, no stall.
